// File: rtl/md_sequencer.sv
// md_sequencer -- multiply/divide unit sequencer with architectural HI/LO.
//
// Accepts one MD operation per cycle while idle. mthi/mtlo write HI/LO at
// the accepting edge. mult/div compute their result at issue into pending
// registers, then a down-counter holds the unit busy for MUL_LAT/DIV_LAT
// cycles before the pending value is committed to {HI,LO}. While busy, any
// MD op or HI/LO read in EX raises stall so the pipeline holds it until the
// first edge after busy falls.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   md_func  in   [2:0] 0 none, 1 mthi, 2 mtlo, 3 mult, 4 div, 5..7 none
//   md_sign  in   1 = signed mult/div, 0 = unsigned
//   rs       in   [31:0] operand A (dividend / multiplicand / mthi-mtlo source)
//   rt       in   [31:0] operand B (divisor / multiplier)
//   hi_read  in   EX instruction is mfhi
//   lo_read  in   EX instruction is mflo
//   busy     out  multiply or divide in progress
//   stall    out  hold EX and upstream this cycle (combinational)
//   hi       out  [31:0] architectural HI
//   lo       out  [31:0] architectural LO
module md_sequencer #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_func,
  input  logic        md_sign,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        hi_read,
  input  logic        lo_read,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [4:0] MUL_CNT = 5'(MUL_LAT);
  localparam logic [4:0] DIV_CNT = 5'(DIV_LAT);

  // Full 64-bit product. Sign- or zero-extending both operands to 64 bits
  // makes the low 64 bits of an unsigned multiply correct for both cases.
  function automatic logic [63:0] mul_full(input logic sgn,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Signed divide is done on magnitudes:
  // quotient is negated when operand signs differ (truncation toward zero),
  // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0. Divide by zero yields {a, all-ones}.
  function automatic logic [63:0] div_full(input logic sgn,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        neg_q;
    logic        neg_r;
    logic [63:0] res;
    neg_r = sgn & a[31];
    neg_q = sgn & (a[31] ^ b[31]);
    ua    = neg_r ? (~a + 32'd1) : a;
    ub    = (sgn & b[31]) ? (~b + 32'd1) : b;
    if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else begin
      uq  = ua / ub;
      ur  = ua % ub;
      res = {(neg_r ? (~ur + 32'd1) : ur), (neg_q ? (~uq + 32'd1) : uq)};
    end
    return res;
  endfunction

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic [63:0] mul_res;
  logic [63:0] div_res;
  logic        md_req;

  assign mul_res = mul_full(md_sign, rs, rt);
  assign div_res = div_full(md_sign, rs, rt);

  assign busy   = (state != IDLE);
  assign md_req = (md_func >= 3'd1) && (md_func <= 3'd4);
  assign stall  = busy & (md_req | hi_read | lo_read);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          case (md_func)
            3'd1: hi <= rs;
            3'd2: lo <= rs;
            3'd3: begin
              pend_hi <= mul_res[63:32];
              pend_lo <= mul_res[31:0];
              cnt     <= MUL_CNT;
              state   <= MUL;
            end
            3'd4: begin
              pend_hi <= div_res[63:32];
              pend_lo <= div_res[31:0];
              cnt     <= DIV_CNT;
              state   <= DIV;
            end
            default: ;
          endcase
        end
        MUL, DIV: begin
          // Commit on the last busy edge so a held op sees IDLE next edge.
          if (cnt == 5'd1) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            cnt   <= 5'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int SBN     = 1024;
  localparam int DXN     = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  md_func = 3'd0;
  logic        md_sign = 1'b0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        hi_read = 1'b0;
  logic        lo_read = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  md_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .md_func(md_func), .md_sign(md_sign),
    .rs(rs), .rt(rt), .hi_read(hi_read), .lo_read(lo_read),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference arithmetic at 64-bit integer level.
  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint x;
    longint y;
    longint p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return 64'(p);
  endfunction

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint x;
    longint y;
    longint q;
    longint r;
    logic [63:0] res;
    if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else begin
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
      q = x / y;
      r = x - q * y;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  // Reference model: remaining busy cycles, architectural HI/LO, pending result.
  int          m_cnt = 0;
  logic [31:0] mh = 32'd0;
  logic [31:0] ml = 32'd0;
  logic [31:0] ph = 32'd0;
  logic [31:0] pl = 32'd0;
  logic [63:0] t64;
  int          cyc = 0;
  bit          acc = 1'b0;

  // Scoreboard FIFO (model writes, monitor reads).
  int          sb_due [SBN];
  logic [31:0] sb_hi  [SBN];
  logic [31:0] sb_lo  [SBN];
  int          wp = 0;
  int          rp = 0;

  // Directed expectations with hand-derived constants (stimulus writes, monitor reads).
  int          dx_due [DXN];
  logic [31:0] dx_hi  [DXN];
  logic [31:0] dx_lo  [DXN];
  int          dwp = 0;
  int          drp = 0;

  int n_tests = 0;
  int n_fail  = 0;
  bit done = 1'b0;
  bit fin  = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; mh = 32'd0; ml = 32'd0; ph = 32'd0; pl = 32'd0;
      cyc = 0; acc = 1'b0;
    end else begin
      cyc = cyc + 1;
      acc = (m_cnt == 0);
      if (m_cnt == 0) begin
        case (md_func)
          3'd1: begin
            mh = rs;
            sb_due[wp % SBN] = cyc; sb_hi[wp % SBN] = mh; sb_lo[wp % SBN] = ml; wp = wp + 1;
          end
          3'd2: begin
            ml = rs;
            sb_due[wp % SBN] = cyc; sb_hi[wp % SBN] = mh; sb_lo[wp % SBN] = ml; wp = wp + 1;
          end
          3'd3: begin
            t64 = ref_mul(md_sign, rs, rt);
            ph = t64[63:32]; pl = t64[31:0]; m_cnt = MUL_LAT;
            sb_due[wp % SBN] = cyc + MUL_LAT; sb_hi[wp % SBN] = ph; sb_lo[wp % SBN] = pl; wp = wp + 1;
          end
          3'd4: begin
            t64 = ref_div(md_sign, rs, rt);
            ph = t64[63:32]; pl = t64[31:0]; m_cnt = DIV_LAT;
            sb_due[wp % SBN] = cyc + DIV_LAT; sb_hi[wp % SBN] = ph; sb_lo[wp % SBN] = pl; wp = wp + 1;
          end
          default: ;
        endcase
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          mh = ph;
          ml = pl;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      rp  = wp;
      drp = dwp;
    end else begin
      chk("busy", 32'(busy), 32'(m_cnt != 0));
      chk("stall", 32'(stall),
          32'((m_cnt != 0) && ((md_func inside {[3'd1:3'd4]}) || hi_read || lo_read)));
      chk("arch_hi", hi, mh);
      chk("arch_lo", lo, ml);
      if (rp != wp && sb_due[rp % SBN] <= cyc) begin
        chk("sb_hi", hi, sb_hi[rp % SBN]);
        chk("sb_lo", lo, sb_lo[rp % SBN]);
        rp = rp + 1;
      end
      if (drp != dwp && dx_due[drp % DXN] <= cyc) begin
        chk("dir_hi", hi, dx_hi[drp % DXN]);
        chk("dir_lo", lo, dx_lo[drp % DXN]);
        drp = drp + 1;
      end
      if (done && !fin) begin
        chk("sb_drained", 32'(rp), 32'(wp));
        chk("dir_drained", 32'(drp), 32'(dwp));
        fin = 1'b1;
      end
    end
  end

  task automatic drive(input logic [2:0] f, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic hr, input logic lr);
    md_func = f; md_sign = s; rs = a; rt = b; hi_read = hr; lo_read = lr;
  endtask

  // Present an op and hold it until the model accepts it; then go idle.
  task automatic issue(input logic [2:0] f, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic hr, input logic lr, output int c);
    bit got;
    got = 1'b0;
    c = 0;
    drive(f, s, a, b, hr, lr);
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge clk);
      #1;
      if (acc) begin
        got = 1'b1;
        c = cyc;
      end
    end
    if (!got) begin
      $display("FAIL issue_timeout: op %0d never accepted, expected acceptance within 64 cycles", f);
      $fatal(1, "issue timeout");
    end
    drive(3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic dexp(input int due, input logic [31:0] h, input logic [31:0] l);
    dx_due[dwp % DXN] = due; dx_hi[dwp % DXN] = h; dx_lo[dwp % DXN] = l;
    dwp = dwp + 1;
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'($urandom_range(0, 15));
      default: v = 32'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int c;
    int c2;
    int r;
    logic [2:0] f;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Unsigned 0xFFFFFFFF * 2, no reads while busy.
    issue(3'd3, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, c);
    dexp(c + MUL_LAT, 32'h1, 32'hFFFF_FFFE);
    repeat (7) @(posedge clk);
    #1;

    // Signed -7 / 2.
    issue(3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, c);
    dexp(c + DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    repeat (12) @(posedge clk);
    #1;

    // Divide by zero, then back-to-back signed overflow divide.
    issue(3'd4, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, c);
    dexp(c + DIV_LAT, 32'd5, 32'hFFFF_FFFF);
    issue(3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, c2);
    dexp(c2 + DIV_LAT, 32'h0, 32'h8000_0000);
    repeat (12) @(posedge clk);
    #1;

    // mflo arriving two cycles into a multiply stalls until LO is written.
    issue(3'd3, 1'b0, 32'd3, 32'd7, 1'b0, 1'b0, c);
    dexp(c + MUL_LAT, 32'h0, 32'd21);
    @(posedge clk);
    #1;
    issue(3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, c2);
    repeat (2) @(posedge clk);
    #1;

    // mthi held behind a signed multiply (-3 * 5).
    issue(3'd3, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, c);
    dexp(c + MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    issue(3'd1, 1'b0, 32'hABCD_0123, 32'd0, 1'b0, 1'b0, c2);
    dexp(c2, 32'hABCD_0123, 32'hFFFF_FFF1);
    repeat (2) @(posedge clk);
    #1;

    // Reset four cycles into a divide discards the result; mtlo right after.
    issue(3'd4, 1'b1, 32'd100, 32'd7, 1'b0, 1'b0, c);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    issue(3'd2, 1'b0, 32'h1234, 32'd0, 1'b0, 1'b0, c);
    dexp(c, 32'h0, 32'h1234);
    repeat (12) @(posedge clk);
    #1;

    // Randomized traffic, ops held while stalled.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 11));
      f = (r < 8) ? 3'(r) : ((r < 10) ? 3'd3 : 3'd4);
      issue(f, 1'($urandom_range(0, 1)), rnd_op(), rnd_op(),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), c);
    end

    repeat (DIV_LAT + 4) @(posedge clk);
    #1 done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
